uart_rx_byte: RTL and testbench

- Serial receive front end; sits directly upstream of the with_uart command/control logic.
- Synchronises the board `fpga_rx` pin and recovers 8N1 frames, with optional parity.
- Presents each received byte on a valid/ready handshake.
- Reports framing, parity and overrun errors so the consumer can drive `led2` diagnostics.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_sampler.sv | 71 +++++++
 rtl/uart_rx_byte.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_pkg : state encoding and sampling constants shared by UART RX/TX    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  // Majority-vote sample points relative to the bit centre (cnt = HALF)
  localparam int VOTE_OFS_EARLY = -1;
  localparam int VOTE_OFS_MID   = 0;
  localparam int VOTE_OFS_LATE  = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_sampler : input synchroniser, bit timer and 3-sample voter       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic fpga_rx,
  input  logic restart,
  output logic rxs,
  output logic sample_strobe,
  output logic bit_end,
  output logic bit_val
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int HALF  = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_EARLY = CNT_W'(HALF + VOTE_OFS_EARLY);
  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(HALF + VOTE_OFS_MID);
  localparam logic [CNT_W-1:0] CNT_LATE  = CNT_W'(HALF + VOTE_OFS_LATE);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   early_q;
  logic                   mid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], fpga_rx};
    end
  end

  assign rxs           = sync_q[SYNC_STAGES-1];
  assign sample_strobe = (cnt_q == CNT_LATE);
  assign bit_end       = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      early_q <= 1'b1;
      mid_q   <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      if (cnt_q == CNT_EARLY) early_q <= rxs;
      if (cnt_q == CNT_MID)   mid_q   <= rxs;
    end
  end

  // The late sample is the live rxs, so the vote resolves on the strobe cycle
  assign bit_val = majority3(early_q, mid_q, rxs);

endmodule
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_byte : 8N1 UART receiver with valid/ready output and error flags |
// |                define UART_RX_PARITY_EN for 8E1 frames with parity check |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fpga_rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      framing_err,
  output logic                      parity_err,
  output logic                      overrun,
  input  logic                      overrun_clr,
  output logic                      busy
);

  localparam int BIDX_W = $clog2(UART_DATA_BITS);
  localparam logic [BIDX_W-1:0] LAST_BIT = BIDX_W'(UART_DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam uart_state_e AFTER_DATA = ST_PARITY;
`else
  localparam uart_state_e AFTER_DATA = ST_STOP;
`endif

  logic rxs;
  logic sample_strobe;
  logic bit_end;
  logic bit_val;
  logic restart;
  logic byte_done;

  uart_state_e               state_q, state_d;
  logic [BIDX_W-1:0]         bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      ferr_q, ferr_d;
  logic                      over_q, over_d;
`ifdef UART_RX_PARITY_EN
  logic                      par_bad_q, par_bad_d;
  logic                      perr_q;
`endif

  uart_rx_sampler #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_sampler (
    .clk           (clk),
    .reset         (reset),
    .fpga_rx       (fpga_rx),
    .restart       (restart),
    .rxs           (rxs),
    .sample_strobe (sample_strobe),
    .bit_end       (bit_end),
    .bit_val       (bit_val)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    restart   = 1'b0;
    byte_done = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Hold the timer at zero so bit timing starts from the falling edge
        restart = 1'b1;
        if (!rxs) state_d = ST_START;
      end
      ST_START: begin
        if (sample_strobe && bit_val) begin
          state_d = ST_IDLE;
        end else if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (sample_strobe) shift_d = {bit_val, shift_q[UART_DATA_BITS-1:1]};
        if (bit_end) begin
          bit_idx_d = bit_idx_q + BIDX_W'(1);
          if (bit_idx_q == LAST_BIT) state_d = AFTER_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (sample_strobe) par_bad_d = (^shift_q) ^ bit_val;
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (sample_strobe) begin
          if (bit_val) begin
            byte_done = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    over_d  = over_q;
    if (byte_done && (!valid_q || rx_ready)) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
    // A fresh overrun takes priority over a simultaneous clear
    if (byte_done && valid_q && !rx_ready) over_d = 1'b1;
    else if (overrun_clr)                  over_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      over_q    <= over_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      perr_q    <= byte_done & par_bad_q;
    end
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign framing_err = ferr_q;
  assign overrun     = over_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_rx_byte : directed frames against a transaction-level RX model   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_uart_rx_byte;

  localparam int C    = 8;
  localparam int S    = 2;
  localparam int HALF = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_IDX = 10;
  localparam bit PAR      = 1'b1;
  localparam int LAT_LIT  = 89;
`else
  localparam int STOP_IDX = 9;
  localparam bit PAR      = 1'b0;
  localparam int LAT_LIT  = 81;
`endif
  // Start-edge drive cycle to the edge where the stop-bit result appears
  localparam int LAT = S + 3 + HALF + STOP_IDX * C;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fpga_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic       overrun_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       framing_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  uart_rx_byte #(.CLKS_PER_BIT(C), .SYNC_STAGES(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .fpga_rx     (fpga_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .framing_err (framing_err),
    .parity_err  (parity_err),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // kind: 0 = good byte, 1 = framing error, 2 = byte with parity error
  typedef struct {
    int         cyc;
    logic [7:0] data;
    int         kind;
  } ev_t;
  ev_t evq[$];

  int   cyc = 0;
  logic rdy_s = 1'b0;
  logic clr_s = 1'b0;
  logic rst_s = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rdy_s <= rx_ready;
    clr_s <= overrun_clr;
    rst_s <= reset;
  end

  logic [7:0] m_data = '0;
  logic       m_valid = 1'b0, m_over = 1'b0, m_ferr = 1'b0, m_perr = 1'b0;
  logic       m_done, m_was_valid;
  ev_t        ev;

  initial forever begin
    @(negedge clk);
    if (rst_s || reset) begin
      m_data = '0; m_valid = 1'b0; m_over = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
      evq.delete();
    end else begin
      m_done = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        n_checks++; n_errors++;
        $display("FAIL event_missed: model event at cycle %0d unprocessed at %0d", evq[0].cyc, cyc);
        void'(evq.pop_front());
      end
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        ev = evq.pop_front();
        if (ev.kind == 1) m_ferr = 1'b1;
        else begin m_done = 1'b1; m_perr = (ev.kind == 2); end
      end
      m_was_valid = m_valid;
      if (m_done && (!m_was_valid || rdy_s)) begin
        m_data = ev.data; m_valid = 1'b1;
      end else if (m_was_valid && rdy_s) begin
        m_valid = 1'b0;
      end
      if (m_done && m_was_valid && !rdy_s) m_over = 1'b1;
      else if (clr_s)                      m_over = 1'b0;
      chk("cyc_rx_data", 32'(rx_data), 32'(m_data));
      chk("cyc_rx_valid", 32'(rx_valid), 32'(m_valid));
      chk("cyc_framing_err", 32'(framing_err), 32'(m_ferr));
      chk("cyc_parity_err", 32'(parity_err), 32'(m_perr));
      chk("cyc_overrun", 32'(overrun), 32'(m_over));
    end
  end

  int         n_ferr = 0, n_perr = 0, rise_cyc = 0;
  logic [7:0] last_data = '0;
  logic       prev_valid = 1'b0;
  always @(negedge clk) begin
    prev_valid <= rx_valid;
    if (rx_valid && !prev_valid) begin
      rise_cyc  <= cyc;
      last_data <= rx_data;
    end
    if (framing_err) n_ferr <= n_ferr + 1;
    if (parity_err)  n_perr <= n_perr + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    fpga_rx = b;
    tick(C);
  endtask

  int last_k = 0, last_ev = 0, n_sent = 0;

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic flip);
    ev_t  e;
    logic p;
    p      = (^d) ^ flip;
    e.cyc  = cyc + LAT;
    e.data = d;
    if (!stop_b)          e.kind = 1;
    else if (PAR && flip) e.kind = 2;
    else                  e.kind = 0;
    last_k  = cyc;
    last_ev = e.cyc;
    evq.push_back(e);
    n_sent++;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR) drive_bit(p);
    drive_bit(stop_b);
  endtask

  task automatic send_partial(input logic [7:0] d, input int nbits);
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(d[i]);
  endtask

  int base;
  int guard;

  initial begin
    tick(3);
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_framing", 32'(framing_err), 32'h0);
    chk("rst_parity", 32'(parity_err), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    tick(4);

    // Clean frame, consumer always ready
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(2 * C);
    chk("a5_data", 32'(last_data), 32'hA5);
    chk("a5_latency", 32'(rise_cyc - last_k), 32'(LAT_LIT));
    chk("a5_no_flags", 32'(n_ferr + n_perr), 32'h0);
    chk("a5_valid_pulse", 32'(rx_valid), 32'h0);

    // Short glitch: false start
    fpga_rx = 1'b0;
    tick(3);
    fpga_rx = 1'b1;
    tick(1);
    chk("glitch_busy_start", 32'(busy), 32'h1);
    tick(8);
    chk("glitch_busy_idle", 32'(busy), 32'h0);
    tick(C);
    chk("glitch_no_ferr", 32'(n_ferr), 32'h0);

    // Framing error followed by a long break
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(10 * C);
    chk("brk_busy_a", 32'(busy), 32'h1);
    chk("brk_ferr_once", 32'(n_ferr), 32'h1);
    tick(10 * C);
    chk("brk_busy_b", 32'(busy), 32'h1);
    chk("brk_no_valid", 32'(rx_valid), 32'h0);
    fpga_rx = 1'b1;
    tick(6);
    chk("brk_busy_released", 32'(busy), 32'h0);
    tick(C);
    send_frame(8'h81, 1'b1, 1'b0);
    tick(2 * C);
    chk("post_brk_data", 32'(last_data), 32'h81);
    chk("post_brk_ferr", 32'(n_ferr), 32'h1);

    // Overrun with consumer stalled
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    tick(2 * C);
    chk("ovr_valid", 32'(rx_valid), 32'h1);
    chk("ovr_data_kept", 32'(rx_data), 32'h11);
    chk("ovr_set", 32'(overrun), 32'h1);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'h0);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    chk("ovr_consumed", 32'(rx_valid), 32'h0);

    // Ready arriving on the exact completion cycle of the second byte
    base  = n_sent;
    guard = 0;
    fork
      begin
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
      end
      begin
        while (n_sent < base + 2 && guard < 4000) begin tick(1); guard++; end
        while (cyc < last_ev - 1 && guard < 4000) begin tick(1); guard++; end
        if (guard >= 4000) begin
          n_checks++; n_errors++;
          $display("FAIL ready_align: wait budget %0d exhausted, required below 4000", guard);
        end
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end
    join
    tick(2 * C);
    chk("swap_data", 32'(rx_data), 32'h22);
    chk("swap_valid", 32'(rx_valid), 32'h1);
    chk("swap_no_overrun", 32'(overrun), 32'h0);

    // Reset in the middle of the data bits
    send_partial(8'h3C, 3);
    chk("mid_busy", 32'(busy), 32'h1);
    reset   = 1'b1;
    fpga_rx = 1'b1;
    #1;
    chk("mid_rst_data", 32'(rx_data), 32'h0);
    chk("mid_rst_valid", 32'(rx_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_overrun", 32'(overrun), 32'h0);
    tick(3);
    reset = 1'b0;
    tick(2 * C);
    rx_ready = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b0);
    tick(2 * C);
    chk("after_rst_data", 32'(last_data), 32'h5A);
    chk("after_rst_valid", 32'(rx_valid), 32'h0);

`ifdef UART_RX_PARITY_EN
    base = n_perr;
    send_frame(8'h07, 1'b1, 1'b1);
    tick(2 * C);
    chk("par_data", 32'(last_data), 32'h07);
    chk("par_err_once", 32'(n_perr - base), 32'h1);
`else
    chk("no_parity_pulses", 32'(n_perr), 32'h0);
`endif

    tick(4);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
